// File: rtl/md5_pkg.sv
// Shared constants and packer state encoding for the md5 feeder path.
package md5_pkg;
   localparam int MD5_BLOCK_BITS  = 512;
   localparam int MD5_BLOCK_BYTES = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_OFFER,
      ST_WAIT_ACK,
      ST_DONE
   } packer_state_e;

   // Byte MSB lands on the lowest bit of its slot.
   function automatic logic [7:0] bit_rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[7-i] = b[i];
      return r;
   endfunction
endpackage

// File: rtl/md5_byte_lane_writer.sv
// Combinational slot write: places byte_in at slot idx of the 512-bit part buffer.
module md5_byte_lane_writer
   import md5_pkg::*;
(
   input  logic [MD5_BLOCK_BITS-1:0] buf_in,
   input  logic [5:0]                idx,
   input  logic [7:0]                byte_in,
   input  logic                      wr_en,
   output logic [MD5_BLOCK_BITS-1:0] buf_out
);
   for (genvar k = 0; k < MD5_BLOCK_BYTES; k++) begin : g_slot
      assign buf_out[8*k +: 8] = (wr_en && idx == 6'(k)) ? bit_rev8(byte_in)
                                                         : buf_in[8*k +: 8];
   end
endmodule

// File: rtl/md5_msg_packer.sv
// Packs a byte stream into 512-bit parts and offers them to md5 with its
// part_in_ready / ready_for_next_part handshake. No padding is done here.
module md5_msg_packer
   import md5_pkg::*;
#(
   parameter int LEN_W = 64
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic [LEN_W-4:0]          msg_len_bytes,
   input  logic [7:0]                byte_in,
   input  logic                      byte_valid,
   output logic                      byte_ready,
   output logic [MD5_BLOCK_BITS-1:0] part_in,
   output logic                      part_in_ready,
   input  logic                      ready_for_next_part,
   output logic [LEN_W-1:0]          total_data_length,
   output logic                      busy,
   output logic                      msg_done
);
   packer_state_e             state;
   logic [LEN_W-4:0]          remaining;
   logic [5:0]                idx;
   logic [MD5_BLOCK_BITS-1:0] buf_next;
   logic                      accept;

   // byte_ready is only ever high in FILL, so accept implies FILL.
   assign accept = byte_valid & byte_ready;

   md5_byte_lane_writer u_writer (
      .buf_in  (part_in),
      .idx     (idx),
      .byte_in (byte_in),
      .wr_en   (accept),
      .buf_out (buf_next)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state             <= ST_IDLE;
         remaining         <= '0;
         idx               <= '0;
         part_in           <= '0;
         part_in_ready     <= 1'b0;
         byte_ready        <= 1'b0;
         total_data_length <= '0;
         busy              <= 1'b0;
         msg_done          <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  total_data_length <= {msg_len_bytes, 3'b000};
                  remaining         <= msg_len_bytes;
                  part_in           <= '0;
                  idx               <= '0;
                  busy              <= 1'b1;
                  msg_done          <= 1'b0;
                  // An empty message still produces one all-zero part.
                  if (msg_len_bytes == '0) begin
                     state      <= ST_OFFER;
                     byte_ready <= 1'b0;
                  end else begin
                     state      <= ST_FILL;
                     byte_ready <= 1'b1;
                  end
               end
            end
            ST_FILL: begin
               if (accept) begin
                  part_in   <= buf_next;
                  idx       <= idx + 6'd1;
                  remaining <= remaining - (LEN_W-3)'(1);
                  if (idx == 6'd63 || remaining == (LEN_W-3)'(1)) begin
                     state      <= ST_OFFER;
                     byte_ready <= 1'b0;
                  end
               end
            end
            ST_OFFER: begin
               if (ready_for_next_part) begin
                  part_in_ready <= 1'b1;
                  state         <= ST_WAIT_ACK;
               end
            end
            ST_WAIT_ACK: begin
               part_in_ready <= 1'b0;
               // md5 signals it has taken the part by dropping ready.
               if (!ready_for_next_part) begin
                  if (remaining != '0) begin
                     part_in    <= '0;
                     idx        <= '0;
                     state      <= ST_FILL;
                     byte_ready <= 1'b1;
                  end else begin
                     state    <= ST_DONE;
                     busy     <= 1'b0;
                     msg_done <= 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_md5_msg_packer.sv
// Directed bench for md5_msg_packer with a cycle-stepped md5 responder.
module tb_md5_msg_packer;
   logic         clk = 1'b0;
   logic         reset_n;
   logic         start;
   logic [60:0]  msg_len_bytes;
   logic [7:0]   byte_in;
   logic         byte_valid;
   logic         byte_ready;
   logic [511:0] part_in;
   logic         part_in_ready;
   logic         ready_for_next_part;
   logic [63:0]  total_data_length;
   logic         busy;
   logic         msg_done;

   int total = 0;
   int bad   = 0;
   logic [7:0] msg [256];

   md5_msg_packer #(.LEN_W(64)) dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .start               (start),
      .msg_len_bytes       (msg_len_bytes),
      .byte_in             (byte_in),
      .byte_valid          (byte_valid),
      .byte_ready          (byte_ready),
      .part_in             (part_in),
      .part_in_ready       (part_in_ready),
      .ready_for_next_part (ready_for_next_part),
      .total_data_length   (total_data_length),
      .busy                (busy),
      .msg_done            (msg_done)
   );

   always #5 clk = ~clk;

   // Expected part p of a len-byte message built from msg[].
   function automatic logic [511:0] exp_part(input int p, input int len);
      logic [511:0] r = '0;
      for (int k = 0; k < 64; k++) begin
         if (64*p + k < len)
            for (int b = 0; b < 8; b++) r[8*k+7-b] = msg[64*p+k][b];
      end
      return r;
   endfunction

   task automatic begin_msg(input int len);
      @(negedge clk);
      msg_len_bytes = 61'(len);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      total++;
      if (total_data_length !== 64'(len) * 64'd8 || busy !== 1'b1 || msg_done !== 1'b0) begin
         bad++;
         $display("FAIL start_latch tdl=%0d busy=%b done=%b exp tdl=%0d busy=1 done=0",
                  total_data_length, busy, msg_done, len*8);
      end
   endtask

   // Runs one full message; md5 keeps ready low for 'hold' cycles before each part.
   task automatic run_msg(input int len, input int hold, input bit inject, output int nparts);
      int ptr = 0, cyc = 0, last_acc = -1, hcnt = hold;
      bit pend = 1'b0, done = 1'b0, injected = 1'b0;
      int exp_parts = (len == 0) ? 1 : (len + 63) / 64;
      nparts = 0;
      ready_for_next_part = (hold == 0);
      begin_msg(len);
      while (!done && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (pend) begin
            total++;
            if (byte_ready !== 1'b0) begin
               bad++;
               $display("FAIL ready_while_pending cyc=%0d got=%b exp=0", cyc, byte_ready);
            end
            total++;
            if (part_in !== exp_part(nparts, len)) begin
               bad++;
               $display("FAIL part_stable part=%0d got=%h exp=%h", nparts, part_in, exp_part(nparts, len));
            end
         end
         if (part_in_ready === 1'b1) begin
            total++;
            if (part_in !== exp_part(nparts, len)) begin
               bad++;
               $display("FAIL part_data part=%0d got=%h exp=%h", nparts, part_in, exp_part(nparts, len));
            end
            if (hold == 0 && last_acc >= 0) begin
               total++;
               if (cyc - last_acc != 2) begin
                  bad++;
                  $display("FAIL offer_latency got=%0d exp=2", cyc - last_acc);
               end
            end
            nparts++;
            pend = 1'b0;
            ready_for_next_part = 1'b0;
            hcnt = hold;
         end else if (hcnt > 0) begin
            hcnt--;
            ready_for_next_part = 1'b0;
         end else begin
            ready_for_next_part = 1'b1;
         end
         if (inject && ptr == 5 && !injected) begin
            start = 1'b1;
            msg_len_bytes = 61'd7;
            injected = 1'b1;
         end else begin
            start = 1'b0;
            msg_len_bytes = 61'(len);
         end
         byte_valid = (ptr < len);
         byte_in = (ptr < len) ? msg[ptr] : 8'h00;
         if (byte_valid && byte_ready) begin
            ptr++;
            if (ptr % 64 == 0 || ptr == len) begin
               pend = 1'b1;
               last_acc = cyc;
            end
         end
         if (msg_done === 1'b1) done = 1'b1;
      end
      byte_valid = 1'b0;
      start = 1'b0;
      total++;
      if (!done) begin
         bad++;
         $display("FAIL msg_timeout len=%0d got=not_done exp=done", len);
      end
      total++;
      if (nparts != exp_parts || ptr != len) begin
         bad++;
         $display("FAIL part_count len=%0d parts=%0d bytes=%0d exp parts=%0d bytes=%0d",
                  len, nparts, ptr, exp_parts, len);
      end
      total++;
      if (busy !== 1'b0 || msg_done !== 1'b1 || byte_ready !== 1'b0 ||
          total_data_length !== 64'(len) * 64'd8) begin
         bad++;
         $display("FAIL done_state busy=%b done=%b rdy=%b tdl=%0d exp 0 1 0 %0d",
                  busy, msg_done, byte_ready, total_data_length, len*8);
      end
   endtask

   task automatic test_reset();
      total++;
      if (byte_ready !== 1'b0 || busy !== 1'b0 || msg_done !== 1'b0 || part_in_ready !== 1'b0 ||
          part_in !== '0 || total_data_length !== '0) begin
         bad++;
         $display("FAIL reset_values rdy=%b busy=%b done=%b pir=%b exp all 0",
                  byte_ready, busy, msg_done, part_in_ready);
      end
      for (int i = 0; i < 20; i++) msg[i] = 8'(8'hA0 + i);
      ready_for_next_part = 1'b1;
      begin_msg(20);
      byte_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         byte_in = msg[i];
         @(negedge clk);
      end
      byte_valid = 1'b0;
      total++;
      if (part_in === '0 || byte_ready !== 1'b1) begin
         bad++;
         $display("FAIL mid_fill rdy=%b part_zero=%b exp rdy=1 part_zero=0", byte_ready, part_in === '0);
      end
      #2 reset_n = 1'b0;
      #1;
      total++;
      if (byte_ready !== 1'b0 || busy !== 1'b0 || msg_done !== 1'b0 || part_in_ready !== 1'b0 ||
          part_in !== '0 || total_data_length !== '0) begin
         bad++;
         $display("FAIL async_reset rdy=%b busy=%b tdl=%0d exp all 0", byte_ready, busy, total_data_length);
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (byte_ready !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_idle rdy=%b busy=%b exp 0 0", byte_ready, busy);
      end
   endtask

   task automatic test_abc();
      int n;
      msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
      run_msg(3, 0, 1'b0, n);
      total++;
      if (part_in[23:0] !== 24'hC64686 || part_in[511:24] !== '0) begin
         bad++;
         $display("FAIL abc_bits got=%h exp=c64686", part_in[23:0]);
      end
      total++;
      if (total_data_length !== 64'd24) begin
         bad++;
         $display("FAIL abc_len got=%0d exp=24", total_data_length);
      end
   endtask

   task automatic test_exact_64();
      int n;
      for (int i = 0; i < 64; i++) msg[i] = 8'(i);
      run_msg(64, 0, 1'b0, n);
      total++;
      if (part_in[7:0] !== 8'h00 || part_in[15:8] !== 8'h80 || part_in[511:504] !== 8'hFC) begin
         bad++;
         $display("FAIL full_slots got=%h exp=fc..8000", part_in[511:496]);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total++;
         if (part_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL extra_offer cyc=%0d got=1 exp=0", c);
         end
      end
   endtask

   task automatic test_held_130();
      int n;
      for (int i = 0; i < 130; i++) msg[i] = 8'((i * 37 + 11) ^ (i >> 2));
      run_msg(130, 20, 1'b0, n);
   endtask

   task automatic test_zero_len();
      int n;
      run_msg(0, 0, 1'b0, n);
      total++;
      if (part_in !== '0 || total_data_length !== '0) begin
         bad++;
         $display("FAIL zero_len part_zero=%b tdl=%0d exp 1 0", part_in === '0, total_data_length);
      end
   endtask

   task automatic test_start_in_fill();
      int n;
      for (int i = 0; i < 70; i++) msg[i] = 8'(255 - 3*i);
      run_msg(70, 0, 1'b1, n);
   endtask

   task automatic test_back_to_back();
      int n;
      for (int i = 0; i < 5; i++) msg[i] = 8'(8'h10 << (i % 4));
      run_msg(5, 0, 1'b0, n);
      run_msg(65, 3, 1'b0, n);
   endtask

   initial begin
      reset_n = 1'b0;
      start = 1'b0;
      msg_len_bytes = '0;
      byte_in = '0;
      byte_valid = 1'b0;
      ready_for_next_part = 1'b0;
      for (int i = 0; i < 256; i++) msg[i] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_abc();
      test_exact_64();
      test_held_130();
      test_zero_len();
      test_start_in_fill();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
